// File: rtl/mem_access_controller.sv
// Data-memory sequencer for the microprogrammed control unit: MOV/MOC handshake,
// big-endian byte lanes, misalignment rejection and a fixed wait-state RAM access.
module mem_access_controller #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MOV,
    input  logic              ReadWrite,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              MOC,
    output logic              err,
    output logic [DATA_W-1:0] rdata_out,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        rw_q;
    logic        sx_q;

    logic        legal;
    logic [3:0]  be_n;
    logic [31:0] lanes_n;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Request decode: legality, byte enables and lane-positioned write data.
    always_comb begin
        legal   = 1'b1;
        be_n    = 4'b0000;
        lanes_n = 32'h0;
        case (size)
            2'b00: begin
                be_n = 4'b1000 >> addr[1:0];
                case (addr[1:0])
                    2'd0:    lanes_n = {wdata[7:0], 24'h0};
                    2'd1:    lanes_n = {8'h0, wdata[7:0], 16'h0};
                    2'd2:    lanes_n = {16'h0, wdata[7:0], 8'h0};
                    default: lanes_n = {24'h0, wdata[7:0]};
                endcase
            end
            2'b01: begin
                legal   = ~addr[0];
                be_n    = addr[1] ? 4'b0011 : 4'b1100;
                lanes_n = addr[1] ? {16'h0, wdata[15:0]} : {wdata[15:0], 16'h0};
            end
            2'b10: begin
                legal   = (addr[1:0] == 2'b00);
                be_n    = 4'b1111;
                lanes_n = wdata;
            end
            default: legal = 1'b0;
        endcase
    end

    // Read path: pick the addressed lane(s) and right-justify with extension.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = mem_rdata[31:24];
            2'd1:    rd_byte = mem_rdata[23:16];
            2'd2:    rd_byte = mem_rdata[15:8];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (size_q)
            2'b00:   rd_ext = {{24{sx_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{sx_q & rd_half[15]}}, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            off_q     <= 2'd0;
            size_q    <= 2'd0;
            rw_q      <= 1'b0;
            sx_q      <= 1'b0;
            MOC       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MOV) begin
                        off_q  <= addr[1:0];
                        size_q <= size;
                        rw_q   <= ReadWrite;
                        sx_q   <= sign_ext;
                        busy   <= 1'b1;
                        if (legal) begin
                            state     <= ACCESS;
                            cnt       <= 4'(WAIT_STATES);
                            mem_en    <= 1'b1;
                            mem_we    <= ~ReadWrite;
                            mem_addr  <= addr[ADDR_W-1:2];
                            mem_be    <= be_n;
                            mem_wdata <= lanes_n;
                        end else begin
                            state <= DONE;
                            MOC   <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // MOV is deliberately ignored here; a started access always finishes.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        mem_be <= 4'b0000;
                        MOC    <= 1'b1;
                        err    <= 1'b0;
                        if (rw_q)
                            rdata_out <= rd_ext;
                    end
                end
                DONE: begin
                    if (!MOV) begin
                        state <= IDLE;
                        MOC   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Scoreboard bench: byte-array reference memory, queue of expected completions,
// independent MOC monitor plus per-access handshake/latency checks.
module tb_mem_access_controller;

    localparam int ADDR_W = 8;
    localparam int WS     = 2;

    logic        clk = 1'b0;
    logic        reset, MOV, ReadWrite, sign_ext;
    logic [1:0]  size;
    logic [ADDR_W-1:0] addr;
    logic [31:0] wdata, rdata_out, mem_wdata, mem_rdata;
    logic        MOC, err, busy, mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [ADDR_W-3:0] mem_addr;

    mem_access_controller #(.ADDR_W(ADDR_W), .DATA_W(32), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .MOV(MOV), .ReadWrite(ReadWrite), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .MOC(MOC), .err(err),
        .rdata_out(rdata_out), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT (word organised, combinational read).
    logic [31:0] ram [64];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk)
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];

    // Reference model: plain big-endian byte memory.
    logic [7:0]  refb [256];
    logic [31:0] exp_rd;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          en_cyc;
        int          we_cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: pops one expectation on every rising MOC.
    int   en_c = 0, we_c = 0;
    logic moc_d = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            en_c = 0; we_c = 0; moc_d = 1'b0;
        end else begin
            if (mem_en) en_c++;
            if (mem_we) we_c++;
            if (MOC && !moc_d) begin
                if (sb.size() == 0) begin
                    chk("unexpected_moc", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    chk("rdata_out", rdata_out, e.rd);
                    chk("mem_en_cycles", en_c, e.en_cyc);
                    chk("mem_we_cycles", we_c, e.we_cyc);
                end
                en_c = 0; we_c = 0;
            end
            moc_d = MOC;
        end
    end

    task automatic poke(input int w, input logic [31:0] v);
        ram[w] = v;
        for (int j = 0; j < 4; j++) refb[4*w + j] = v[8*(3-j) +: 8];
    endtask

    task automatic issue(input logic rw, input logic [1:0] sz, input logic sx,
                         input logic [7:0] a, input logic [31:0] wd, input logic drop);
        logic        legal;
        int          n, edges;
        logic [3:0]  ebe;
        logic [31:0] ewd, v, mask;
        exp_t        e;
        legal = (sz != 2'b11) && !(sz == 2'b01 && a[0]) && !(sz == 2'b10 && a[1:0] != 2'b00);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ebe = 4'b0; ewd = 32'h0; v = 32'h0;
        if (legal) begin
            for (int j = 0; j < n; j++) begin
                int lane;
                lane = int'(a[1:0]) + j;
                ebe[3-lane] = 1'b1;
                if (!rw) begin
                    ewd[8*(3-lane) +: 8] = wd[8*(n-1-j) +: 8];
                    refb[int'(a) + j]    = wd[8*(n-1-j) +: 8];
                end else begin
                    v = (v << 8) | {24'h0, refb[int'(a) + j]};
                end
            end
            if (rw) begin
                mask = (n == 4) ? 32'h0 : (32'hFFFF_FFFF << (8*n));
                if (sx && v[8*n-1]) v = v | mask;
                exp_rd = v;
            end
        end
        e.err = ~legal; e.rd = exp_rd;
        e.en_cyc = legal ? WS + 1 : 0;
        e.we_cyc = (legal && !rw) ? WS + 1 : 0;
        sb.push_back(e);

        MOV = 1'b1; ReadWrite = rw; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        chk("busy_accept", {31'd0, busy}, 32'd1);
        chk("mem_en_accept", {31'd0, mem_en}, {31'd0, legal});
        if (legal) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, ~rw});
            chk("mem_addr", {26'd0, mem_addr}, {26'd0, a[7:2]});
            chk("mem_be", {28'd0, mem_be}, {28'd0, ebe});
            if (!rw) chk("mem_wdata", mem_wdata, ewd);
        end
        if (drop) MOV = 1'b0;
        edges = 0;
        while (!MOC && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("moc_latency", edges, legal ? WS + 1 : 0);
        if (drop) begin
            @(posedge clk); #1;
            chk("moc_pulse_end", {31'd0, MOC}, 32'd0);
            chk("busy_after_drop", {31'd0, busy}, 32'd0);
        end else begin
            repeat (2) begin
                @(posedge clk); #1;
                chk("moc_held", {31'd0, MOC}, 32'd1);
                chk("no_reaccept", {31'd0, mem_en}, 32'd0);
            end
            MOV = 1'b0;
            @(posedge clk); #1;
            chk("moc_release", {31'd0, MOC}, 32'd0);
            chk("err_release", {31'd0, err}, 32'd0);
            chk("busy_release", {31'd0, busy}, 32'd0);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_moc"}, {31'd0, MOC}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, "_addr"}, {26'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rdata"}, rdata_out, 32'd0);
    endtask

    initial begin
        int we_seen;
        reset = 1'b1; MOV = 1'b0; ReadWrite = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0; exp_rd = 32'h0;
        for (int w = 0; w < 64; w++) poke(w, $urandom);
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        poke(4, 32'hDEADBEEF);
        issue(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0);
        poke(4, 32'h12345680);
        issue(1'b1, 2'b00, 1'b1, 8'h13, 32'h0, 1'b0);
        issue(1'b1, 2'b00, 1'b0, 8'h13, 32'h0, 1'b0);
        issue(1'b1, 2'b01, 1'b1, 8'h12, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 8'h21, 32'h000000AB, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 8'h06, 32'h0, 1'b0);
        issue(1'b1, 2'b11, 1'b0, 8'h04, 32'h0, 1'b0);
        issue(1'b1, 2'b01, 1'b1, 8'h31, 32'h0, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 8'h20, 32'h0, 1'b1);

        // Reset in the second ACCESS cycle of a word write.
        MOV = 1'b1; ReadWrite = 1'b0; size = 2'b10; addr = 8'h40; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_zero("midreset");
        reset = 1'b0; MOV = 1'b0;
        for (int j = 0; j < 4; j++) refb[8'h40 + j] = wdata[8*(3-j) +: 8];
        exp_rd = 32'h0;
        we_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_we) we_seen++;
        end
        chk("we_after_reset", we_seen, 0);
        issue(1'b1, 2'b10, 1'b0, 8'h40, 32'h0, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 8'h42, 32'h0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic [1:0] sz;
            logic [7:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        for (int w = 0; w < 64; w++)
            chk("ram_contents", ram[w], {refb[4*w], refb[4*w+1], refb[4*w+2], refb[4*w+3]});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
